// File: rtl/lcd_text_arbiter_if.sv
// ----------------------------------------------------------------------------
// lcd_text_arbiter_if
//   Bundles the signals between the text sources / LCD row driver and the
//   lcd_text_arbiter.
//
//   Handshake: each source holds its req level for as long as its text should
//   be shown. The row driver raises frame_done after the last character of
//   row 2. The rising edge of frame_done is the only point where the arbiter
//   samples req and updates gnt/owner/rows, so no further valid/ready pairing
//   is needed.
//
//   Signals
//     req          source -> arb   level request per source
//     row1_in      source -> arb   row-1 text, source i at [i*128 +: 128]
//     row2_in      source -> arb   row-2 text, source i at [i*128 +: 128]
//     frame_done   driver -> arb   high after the last char of row 2 is written
//     gnt          arb -> source   one-hot grant, zero when idle
//     owner_valid  arb -> driver   an owner is granted
//     owner_id     arb -> driver   index of the current owner (0 when idle)
//     row_1/row_2  arb -> driver   text to display
//   Modports: master (sources/driver side), slave (arbiter side).
// ----------------------------------------------------------------------------
interface lcd_text_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*128-1:0] row1_in;
    logic [NUM_REQ*128-1:0] row2_in;
    logic                   frame_done;
    logic [NUM_REQ-1:0]     gnt;
    logic                   owner_valid;
    logic [ID_W-1:0]        owner_id;
    logic [127:0]           row_1;
    logic [127:0]           row_2;

    modport master (
        output req, row1_in, row2_in, frame_done,
        input  gnt, owner_valid, owner_id, row_1, row_2
    );

    modport slave (
        input  req, row1_in, row2_in, frame_done,
        output gnt, owner_valid, owner_id, row_1, row_2
    );
endinterface

// File: rtl/lcd_text_arbiter.sv
// ----------------------------------------------------------------------------
// lcd_text_arbiter
//   Shares a 16x2 character LCD between NUM_REQ text sources. One owner at a
//   time drives the row driver; ownership only changes on a frame boundary
//   (rising edge of frame_done), so a displayed frame never mixes sources.
//   Round-robin among requesters, with a minimum hold of HOLD_FRAMES frames
//   while others wait.
//
//   Optional feature macro: LCD_ARB_PRIO_EN
//     defined     : source 0 preempts any other owner on the next frame
//                   boundary and, once owner, never rotates out while req[0]=1.
//     not defined : pure round-robin, all sources equal.
//
//   Ports
//     clk             clock
//     rst_n           asynchronous active-low reset
//     bus             lcd_text_arbiter_if.slave (req, rows in, frame_done,
//                     gnt, owner_valid, owner_id, row_1, row_2)
//     o_dbg_state     current FSM state (0 = IDLE, 1 = OWN)
//     o_dbg_hold_cnt  frames the current owner has held the LCD
// ----------------------------------------------------------------------------
module lcd_text_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         HOLD_FRAMES = 8,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    lcd_text_arbiter_if.slave                    bus,
    output logic                                 o_dbg_state,
    output logic [$clog2(HOLD_FRAMES+1)-1:0]     o_dbg_hold_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int HC_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [127:0] BLANK_ROW = {16{BLANK_CHAR}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_fd_d;
    logic [HC_W-1:0]    r_hold_cnt;
    logic [ID_W-1:0]    r_last_owner;
    logic [ID_W-1:0]    r_owner_id;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_owner_valid;
    logic [127:0]       r_row_1;
    logic [127:0]       r_row_2;

    logic               w_fe;
    logic               w_excl;
    logic               w_hit;
    logic [ID_W-1:0]    w_hit_id;
    logic               w_owner_req;
    logic               w_hold_done;
    logic               w_take_new;
    logic               w_go_idle;
    logic [ID_W-1:0]    w_new_id;
    logic [127:0]       w_row1 [NUM_REQ];
    logic [127:0]       w_row2 [NUM_REQ];

    // A level held for several cycles counts as one frame event.
    assign w_fe = bus.frame_done & ~r_fd_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rows
        assign w_row1[g] = bus.row1_in[g*128 +: 128];
        assign w_row2[g] = bus.row2_in[g*128 +: 128];
    end

    // Round-robin search: starts at last_owner+1 and wraps, so last_owner is
    // the final candidate. While an owner exists it is excluded, which makes
    // the same search serve both "owner dropped" and "rotate after hold".
    always_comb begin
        logic [ID_W:0] w_sum;
        logic [ID_W-1:0] w_idx;
        w_excl   = (r_state == ST_OWN);
        w_hit    = 1'b0;
        w_hit_id = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last_owner} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_hit && bus.req[w_idx] && !(w_excl && (w_idx == r_owner_id))) begin
                w_hit    = 1'b1;
                w_hit_id = w_idx;
            end
        end
    end

    // Next-owner decision for the current frame event. Neither take_new nor
    // go_idle means the current owner keeps the LCD.
    always_comb begin
        w_owner_req = bus.req[r_owner_id];
        w_hold_done = (r_hold_cnt >= HC_W'(HOLD_FRAMES));
        w_take_new  = 1'b0;
        w_go_idle   = 1'b0;
        w_new_id    = w_hit_id;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) w_take_new = 1'b1;
                else       w_go_idle  = 1'b1;
            end
            ST_OWN: begin
                if (!w_owner_req) begin
                    if (w_hit) w_take_new = 1'b1;
                    else       w_go_idle  = 1'b1;
                end else if (w_hold_done && w_hit) begin
                    w_take_new = 1'b1;
                end
            end
            default: w_go_idle = 1'b1;
        endcase
`ifdef LCD_ARB_PRIO_EN
        if (bus.req[0]) begin
            if (r_state == ST_IDLE || r_owner_id != '0) begin
                w_take_new = 1'b1;
                w_go_idle  = 1'b0;
                w_new_id   = '0;
            end else begin
                // Source 0 already owns: it never rotates out while requesting.
                w_take_new = 1'b0;
                w_go_idle  = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_fd_d        <= 1'b0;
            r_hold_cnt    <= '0;
            r_last_owner  <= ID_W'(NUM_REQ - 1);
            r_owner_id    <= '0;
            r_gnt         <= '0;
            r_owner_valid <= 1'b0;
            r_row_1       <= BLANK_ROW;
            r_row_2       <= BLANK_ROW;
        end else begin
            r_fd_d <= bus.frame_done;
            if (w_fe) begin
                if (w_take_new) begin
                    r_state       <= ST_OWN;
                    r_owner_id    <= w_new_id;
                    r_last_owner  <= w_new_id;
                    r_gnt         <= NUM_REQ'(1) << w_new_id;
                    r_owner_valid <= 1'b1;
                    r_hold_cnt    <= HC_W'(1);
                    r_row_1       <= w_row1[w_new_id];
                    r_row_2       <= w_row2[w_new_id];
                end else if (w_go_idle) begin
                    r_state       <= ST_IDLE;
                    r_owner_id    <= '0;
                    r_gnt         <= '0;
                    r_owner_valid <= 1'b0;
                    r_hold_cnt    <= '0;
                    r_row_1       <= BLANK_ROW;
                    r_row_2       <= BLANK_ROW;
                end else begin
                    // Keep owner; count saturates at HOLD_FRAMES.
                    if (!w_hold_done) r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    r_row_1 <= w_row1[r_owner_id];
                    r_row_2 <= w_row2[r_owner_id];
                end
            end
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.owner_valid = r_owner_valid;
    assign bus.owner_id    = r_owner_id;
    assign bus.row_1       = r_row_1;
    assign bus.row_2       = r_row_2;
    assign o_dbg_state     = r_state;
    assign o_dbg_hold_cnt  = r_hold_cnt;
endmodule

// File: tb/tb_lcd_text_arbiter.sv
// ----------------------------------------------------------------------------
// tb_lcd_text_arbiter
//   Directed bench for lcd_text_arbiter with NUM_REQ=4, HOLD_FRAMES=8.
//   Source i shows row 1 = 16 x ('A'+i), row 2 = 16 x ('a'+i).
// ----------------------------------------------------------------------------
module tb_lcd_text_arbiter;
    localparam int NUM_REQ     = 4;
    localparam int HOLD_FRAMES = 8;
    localparam logic [127:0] BLANK = {16{8'h20}};

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_text_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    logic       dbg_state;
    logic [3:0] dbg_hold;

    lcd_text_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .HOLD_FRAMES(HOLD_FRAMES),
        .BLANK_CHAR (8'h20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .o_dbg_state   (dbg_state),
        .o_dbg_hold_cnt(dbg_hold)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] txt(input logic [7:0] c);
        return {16{c}};
    endfunction

    task automatic check_owner(input string tag, input logic [3:0] gnt, input logic valid,
                               input logic [1:0] id);
        check({tag, ".gnt"},   128'(bus.gnt), 128'(gnt));
        check({tag, ".valid"}, 128'(bus.owner_valid), 128'(valid));
        check({tag, ".id"},    128'(bus.owner_id), 128'(id));
    endtask

    task automatic check_rows(input string tag, input logic [127:0] r1, input logic [127:0] r2);
        check({tag, ".row_1"}, bus.row_1, r1);
        check({tag, ".row_2"}, bus.row_2, r2);
    endtask

    // ---------------- driver tasks ----------------
    // frame_done high for n cycles, then a low cycle; returns on a negedge
    // with the post-event outputs settled.
    task automatic frame_pulse(input int n);
        @(negedge clk);
        bus.frame_done = 1'b1;
        repeat (n) @(negedge clk);
        bus.frame_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_req(input logic [3:0] r);
        @(negedge clk);
        bus.req = r;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.req        = '0;
        bus.frame_done = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.row1_in[i*128 +: 128] = txt(8'(8'h41 + i));
            bus.row2_in[i*128 +: 128] = txt(8'(8'h61 + i));
        end

        // Reset values
        repeat (2) @(negedge clk);
        check_owner("reset", 4'b0000, 1'b0, 2'd0);
        check_rows("reset", BLANK, BLANK);
        check("reset.hold", 128'(dbg_hold), 128'(0));
        rst_n = 1'b1;

        // 1: idle frame stays blank
        frame_pulse(1);
        check_owner("t1", 4'b0000, 1'b0, 2'd0);
        check_rows("t1", BLANK, BLANK);

        // 2: single requester, 1-clock latency from the rising frame_done
        set_req(4'b0100);
        @(negedge clk);
        check("t2.no_fe", 128'(bus.gnt), 128'(4'b0000));
        bus.frame_done = 1'b1;
        #1;
        check("t2.pre_edge", 128'(bus.gnt), 128'(4'b0000));
        @(negedge clk);
        bus.frame_done = 1'b0;
        check_owner("t2", 4'b0100, 1'b1, 2'd2);
        check_rows("t2", txt(8'h43), txt(8'h63));
        check("t2.hold", 128'(dbg_hold), 128'(1));
        @(negedge clk);

        // 3: contention; owner 2 keeps 7 more frames, 8th rotates to 1
        set_req(4'b0110);
        for (int f = 0; f < 7; f++) exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            frame_pulse(1);
            check("t3.gnt", 128'(bus.gnt), 128'(e));
        end
        check("t3.id", 128'(bus.owner_id), 128'(1));
        check("t3.hold", 128'(dbg_hold), 128'(1));
        check_rows("t3", txt(8'h42), txt(8'h62));

        // 4: owner drops mid-frame; nothing changes until the frame event
        set_req(4'b0000);
        repeat (3) @(negedge clk);
        check_owner("t4.mid", 4'b0010, 1'b1, 2'd1);
        check_rows("t4.mid", txt(8'h42), txt(8'h62));
        frame_pulse(1);
        check_owner("t4", 4'b0000, 1'b0, 2'd0);
        check_rows("t4", BLANK, BLANK);

        // 5: frame_done held 5 cycles is one event
        set_req(4'b0001);
        frame_pulse(5);
        check_owner("t5", 4'b0001, 1'b1, 2'd0);
        check("t5.hold", 128'(dbg_hold), 128'(1));
        check_rows("t5", txt(8'h41), txt(8'h61));

        // 6: owner 2 with hold_cnt=1, then source 0 requests as well
        set_req(4'b0100);
        frame_pulse(1);
        check_owner("t6.setup", 4'b0100, 1'b1, 2'd2);
        check("t6.setup_hold", 128'(dbg_hold), 128'(1));
        set_req(4'b0101);
        frame_pulse(1);
`ifdef LCD_ARB_PRIO_EN
        check_owner("t6", 4'b0001, 1'b1, 2'd0);
        check("t6.hold", 128'(dbg_hold), 128'(1));
        set_req(4'b0001);
`else
        check_owner("t6", 4'b0100, 1'b1, 2'd2);
        check("t6.hold", 128'(dbg_hold), 128'(2));
        set_req(4'b0100);
`endif

        // Sole requester: hold_cnt saturates at HOLD_FRAMES
        repeat (10) frame_pulse(1);
        check("sat.hold", 128'(dbg_hold), 128'(HOLD_FRAMES));
`ifdef LCD_ARB_PRIO_EN
        check("sat.gnt", 128'(bus.gnt), 128'(4'b0001));
`else
        check("sat.gnt", 128'(bus.gnt), 128'(4'b0100));
`endif

        // Asynchronous reset mid-frame, then search restarts at source 0
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_owner("areset", 4'b0000, 1'b0, 2'd0);
        check_rows("areset", BLANK, BLANK);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(4'b1010);
        frame_pulse(1);
        check_owner("post_reset", 4'b0010, 1'b1, 2'd1);
        check_rows("post_reset", txt(8'h42), txt(8'h62));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
